// File: rtl/cp0_regfile.sv
// CP0 register file: Status, Cause, EPC, Count, Compare plus timer pending flag.
// Handles mfc0/mtc0, exception entry and ERET, and drives the PC redirect target.
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_0001,
  parameter int          ST_SHIFT   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic        wsta,
  input  logic        wcau,
  input  logic        wepc,
  input  logic        exception,
  input  logic        eret,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] cause_in,
  output logic [31:0] rdata,
  output logic [31:0] status,
  output logic [31:0] exc_addr,
  output logic        redirect,
  output logic        timer_irq
);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;

  logic [31:0] cause;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        pending;
  logic [31:0] cause_nxt;
  logic [31:0] cause_rd;
  logic        wr_compare;
  logic        timer_hit;

  // Bit 15 of Cause always mirrors the live pending flag, both on capture and readback.
  always_comb begin
    cause_nxt     = cause_in;
    cause_nxt[15] = pending;
    cause_rd      = cause;
    cause_rd[15]  = pending;
  end

  assign wr_compare = mtc0 && (addr == A_COMPARE);
  assign timer_hit  = (count == compare) && (compare != 32'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status  <= STATUS_RST;
      cause   <= 32'd0;
      epc     <= 32'd0;
      count   <= 32'd0;
      compare <= 32'd0;
      pending <= 1'b0;
    end else begin
      if (exception && wsta)                        status <= status << ST_SHIFT;
      else if (eret && wsta)                        status <= status >> ST_SHIFT;
      else if (mtc0 && wsta && (addr == A_STATUS))  status <= wdata;

      if (exception && wcau)                        cause <= cause_nxt;
      else if (mtc0 && wcau && (addr == A_CAUSE))   cause <= wdata;

      if (exception && wepc)                        epc <= pc;
      else if (mtc0 && wepc && (addr == A_EPC))     epc <= wdata;

      if (mtc0 && (addr == A_COUNT)) count <= wdata;
      else                           count <= count + 32'd1;

      if (wr_compare) compare <= wdata;

      // A Compare write clears pending even if the timer matches in the same cycle.
      if (wr_compare)     pending <= 1'b0;
      else if (timer_hit) pending <= 1'b1;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (mfc0) begin
      case (addr)
        A_COUNT:   rdata = count;
        A_COMPARE: rdata = compare;
        A_STATUS:  rdata = status;
        A_CAUSE:   rdata = cause_rd;
        A_EPC:     rdata = epc;
        default:   rdata = 32'd0;
      endcase
    end
  end

  assign redirect  = exception | eret;
  assign exc_addr  = exception ? EXC_VECTOR : (eret ? epc : 32'd0);
  assign timer_irq = pending & status[0] & status[15];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        mfc0, mtc0, wsta, wcau, wepc, exception, eret;
  logic [4:0]  addr;
  logic [31:0] wdata, cause_in;
  logic [31:0] rdata, status, exc_addr;
  logic        redirect, timer_irq;

  int n_chk  = 0;
  int n_fail = 0;

  cp0_regfile dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .mfc0(mfc0), .mtc0(mtc0),
    .wsta(wsta), .wcau(wcau), .wepc(wepc), .exception(exception), .eret(eret),
    .addr(addr), .wdata(wdata), .cause_in(cause_in),
    .rdata(rdata), .status(status), .exc_addr(exc_addr),
    .redirect(redirect), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mfc0 = 0; mtc0 = 0; wsta = 0; wcau = 0; wepc = 0;
    exception = 0; eret = 0; addr = 5'd0; wdata = 32'd0;
  endtask

  // Combinational read of a CP0 register within the current cycle.
  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0 = 1; addr = a;
    #1;
    chk(tag, rdata, exp);
    mfc0 = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle();
    mtc0 = 1; addr = a; wdata = d;
    wsta = (a == 5'd12); wcau = (a == 5'd13); wepc = (a == 5'd14);
    tick();
    idle();
  endtask

  initial begin
    pc = 32'd0; cause_in = 32'd0;
    // 1. reset with every strobe asserted
    rst_n = 0; mfc0 = 1; mtc0 = 1; wsta = 1; wcau = 1; wepc = 1;
    exception = 1; eret = 1; addr = 5'd12; wdata = 32'hFFFF_FFFF;
    pc = 32'h1234_5678; cause_in = 32'hFFFF_FFFF;
    tick();
    tick();
    rst_n = 1;
    idle();
    #1;
    chk("rst_status", status, 32'h1);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    rd("rst_epc", 5'd14, 32'd0);
    rd("rst_count", 5'd9, 32'd0);
    rd("rst_cause", 5'd13, 32'd0);
    rd("rst_compare", 5'd11, 32'd0);
    tick(); tick(); tick();
    rd("count_plus3", 5'd9, 32'd3);

    // 2. mtc0 / mfc0 Status
    wr(5'd12, 32'h0000_8001);
    rd("rd_status", 5'd12, 32'h0000_8001);
    rd("rd_unimpl", 5'd5, 32'd0);
    addr = 5'd12; mfc0 = 0; #1;
    chk("rd_no_mfc0", rdata, 32'd0);

    // 3. exception entry
    wr(5'd12, 32'h1);
    pc = 32'h0040_0100; cause_in = 32'h20;
    exception = 1; wsta = 1; wcau = 1; wepc = 1;
    #1;
    chk("exc_redirect", {31'd0, redirect}, 32'd1);
    chk("exc_addr", exc_addr, 32'h0040_0004);
    tick();
    idle();
    rd("exc_epc", 5'd14, 32'h0040_0100);
    rd("exc_cause", 5'd13, 32'h20);
    chk("exc_status", status, 32'h20);

    // 4. ERET
    eret = 1; wsta = 1;
    #1;
    chk("eret_addr", exc_addr, 32'h0040_0100);
    chk("eret_redirect", {31'd0, redirect}, 32'd1);
    tick();
    idle();
    chk("eret_status", status, 32'h1);
    rd("eret_epc_keep", 5'd14, 32'h0040_0100);

    // 5. timer
    wr(5'd11, 32'd5);
    wr(5'd12, 32'h8001);
    wr(5'd9, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    rd("tmr_count5", 5'd9, 32'd5);
    chk("tmr_irq_before", {31'd0, timer_irq}, 32'd0);
    tick();
    chk("tmr_irq_set", {31'd0, timer_irq}, 32'd1);
    rd("tmr_cause15", 5'd13, 32'h8020);
    tick(); tick();
    chk("tmr_irq_hold", {31'd0, timer_irq}, 32'd1);
    mtc0 = 1; addr = 5'd11; wdata = 32'd0;
    #1;
    chk("tmr_irq_preclear", {31'd0, timer_irq}, 32'd1);
    tick();
    idle();
    chk("tmr_irq_clear", {31'd0, timer_irq}, 32'd0);
    rd("tmr_cause_clr", 5'd13, 32'h20);
    rd("tmr_compare0", 5'd11, 32'd0);

    // clear beats a simultaneous match
    wr(5'd11, 32'd100);
    wr(5'd9, 32'd100);
    mtc0 = 1; addr = 5'd11; wdata = 32'd200;
    tick();
    idle();
    tick();
    chk("tmr_clear_wins", {31'd0, timer_irq}, 32'd0);

    // 6. exception beats mtc0 on EPC
    pc = 32'h0040_0200;
    exception = 1; mtc0 = 1; wepc = 1; addr = 5'd14; wdata = 32'h0000_DEAD;
    tick();
    idle();
    rd("pri_epc", 5'd14, 32'h0040_0200);
    chk("pri_status_keep", status, 32'h8001);
    // eret beats mtc0 on Status
    eret = 1; mtc0 = 1; wsta = 1; addr = 5'd12; wdata = 32'h1234;
    tick();
    idle();
    chk("pri_eret_status", status, 32'h400);
    // Count wrap
    wr(5'd9, 32'hFFFF_FFFF);
    rd("wrap_pre", 5'd9, 32'hFFFF_FFFF);
    tick();
    rd("wrap_post", 5'd9, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
